// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port round-robin arbiter with lock in front of one shared ALU
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic [4:0]       r0_sa,
  input  logic             r0_lock,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  input  logic [4:0]       r1_sa,
  input  logic             r1_lock,
  input  logic [TAG_W-1:0] r1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic [4:0]       alu_sa,
  input  logic [31:0]      alu_res,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_res,
  output logic             rsp_zf
);

  logic lock_q;
  logic owner_q;
  logic last_grant_q;

  logic slot_free;
  logic sel;
  logic sel_valid;
  logic accept;
  logic use_p1;
  logic acc_lock;
  logic [TAG_W-1:0] acc_tag;

  // With nobody valid the pointer still names a port, so at most one ready is ever high.
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    if (lock_q)                    sel = owner_q;
    else if (r0_valid && r1_valid) sel = ~last_grant_q;
    else if (r1_valid)             sel = 1'b1;
    else if (r0_valid)             sel = 1'b0;
    else                           sel = ~last_grant_q;
    sel_valid = sel ? r1_valid : r0_valid;
    accept    = slot_free && sel_valid;
    use_p1    = sel && r1_valid;
    acc_lock  = sel ? r1_lock : r0_lock;
    acc_tag   = sel ? r1_tag : r0_tag;
  end

  assign r0_ready = slot_free && !sel;
  assign r1_ready = slot_free && sel;

  assign alu_a  = use_p1 ? r1_a  : r0_a;
  assign alu_b  = use_p1 ? r1_b  : r0_b;
  assign alu_op = use_p1 ? r1_op : r0_op;
  assign alu_sa = use_p1 ? r1_sa : r0_sa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_tag      <= '0;
      rsp_res      <= '0;
      rsp_zf       <= 1'b0;
      lock_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= sel;
      rsp_tag      <= acc_tag;
      rsp_res      <= alu_res;
      rsp_zf       <= alu_zf;
      last_grant_q <= sel;
      // While locked only the owner can be accepted, so an unlocked op always releases.
      lock_q       <= acc_lock;
      if (acc_lock) owner_q <= sel;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule
